regbus_initiator: RTL
=====================

Name: regbus_initiator

Overview:
- Initiator (driving) end of the register_bus interface: produces the rd/data_in/we write strobe and the rs1/rs2 read addresses consumed by the 8x16 register file, and samples data_rs1/data_rs2.
- Sits between the pipeline (writeback and operand-fetch stages) and the register file.
- Adds valid/ready handshakes, a small posted-write buffer and read-after-write forwarding, so the pipeline never drives the level-sensitive write port directly.

Parameters:
DATA_W, 16, register width
ADDR_W, 3, register index width (8 registers)
WBUF_DEPTH, 2, posted-write buffer entries (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request valid
wr_ready  out  1  write buffer can accept
wr_rd  in  ADDR_W  write destination index
wr_data  in  DATA_W  write data
drain_hold  in  1  inhibit buffer draining (freeze/debug)
wbuf_empty  out  1  no writes pending or in flight
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read FSM idle
rs1  in  ADDR_W  source index 1
rs2  in  ADDR_W  source index 2
rd_rsp_valid  out  1  one-cycle response strobe
rs1_data  out  DATA_W  operand 1
rs2_data  out  DATA_W  operand 2
rb_rd  out  ADDR_W  register_bus rd
rb_data_in  out  DATA_W  register_bus data_in
rb_we  out  1  register_bus we
rb_rs1  out  ADDR_W  register_bus rs1
rb_rs2  out  ADDR_W  register_bus rs2
rb_data_rs1  in  DATA_W  register_bus data_rs1
rb_data_rs2  in  DATA_W  register_bus data_rs2

Behaviour:
- Reset:
  - All outputs 0 except wr_ready=1, rd_req_ready=1, wbuf_empty=1.
  - Buffer empty; read FSM in R_IDLE.
  - Reset mid-operation discards pending writes and any in-flight read. No rb_we pulse and no rd_rsp_valid follow.
- Bus outputs:
  - All rb_* outputs are driven directly from flops, because the register file write is level-sensitive and must see glitch-free signals.
  - rb_rd/rb_data_in hold their last values while rb_we=0.
- Write path:
  - FIFO of {rd,data}; push on wr_valid&&wr_ready.
  - wr_ready = !full. There is no same-cycle push-when-full, even if a pop occurs.
  - Each edge with the buffer non-empty and drain_hold=0: pop the head into rb_rd/rb_data_in and set rb_we=1. Otherwise rb_we=0.
  - rb_we is therefore a one-cycle pulse per write; back-to-back writes give consecutive pulses.
  - Unstalled latency: a write accepted at edge N asserts rb_we in the cycle after edge N+1.
  - Writes reach the bus in acceptance order.
  - wbuf_empty = buffer empty && !rb_we.
- Read FSM:
  - R_IDLE, rd_req_ready=1. On accept, latch rs1/rs2 into rb_rs1/rb_rs2 and go to R_ADDR.
  - R_ADDR, one cycle. At the closing edge capture operands into rs1_data/rs2_data, set rd_rsp_valid=1 and go to R_RESP.
  - R_RESP, one cycle with rd_rsp_valid=1, then return to R_IDLE with rd_rsp_valid=0.
  - rd_req_ready=0 in R_ADDR and R_RESP. One read is outstanding at most; throughput is one read per 3 cycles.
  - rs1_data/rs2_data hold their values until the next capture.
- Forwarding, evaluated per operand at the capture edge:
  - Source priority: youngest matching buffer entry (before that edge's pop), then the current bus write (rb_we && rb_rd==index), then rb_data_rsN.
  - A read observes every write accepted strictly before its capture edge.
  - Writes accepted on the capture edge itself are not observed.
  - rs1==rs2 is legal; both operands get the same value.
- Register index 0 is an ordinary register; no hardwired zero.

Decomposition:
- Package regbus_pkg:
  - ADDR_W and DATA_W defaults
  - rd_state_t enum {R_IDLE, R_ADDR, R_RESP}
  - wbuf_entry_t struct {rd, data}
- Sub-module regbus_wbuf: the FIFO plus a combinational youngest-match search with two lookup ports (hit, data).

Test Plan:
- Basic write/read: write r3=0xBEEF, wait 3 cycles, then read rs1=3, rs2=0 -> exactly one rb_we pulse with rb_rd=3, rb_data_in=0xBEEF in the 2nd cycle after accept; rd_rsp_valid 2 cycles after read accept with rs1_data=0xBEEF, rs2_data=0x0000.
- Same-cycle forwarding: write r5=0x1234 and read rs1=5 accepted on the same edge -> rs1_data=0x1234.
- Youngest match wins: drain_hold=1, write r2=0x0001 then r2=0x0002, then read rs1=rs2=2 -> both operands 0x0002.
- Backpressure and ordering: with drain_hold=1, two writes accepted -> wr_ready=0 and a third write stalls. Release drain_hold -> three rb_we pulses on consecutive cycles in order, then wbuf_empty=1.
- Read handshake: rd_req_valid held high -> rd_req_ready=0 in R_ADDR and R_RESP; a new request is accepted only every 3rd cycle.
- Reset mid-operation: drain_hold=1 with two writes pending and a read in R_ADDR, then assert rst for 1 cycle -> no rb_we, no rd_rsp_valid, reset values on outputs. A later read of those registers returns the old values.

Source files
------------

// File: rtl/regbus_pkg.sv
// Shared types and default widths for the register_bus initiator.
//   REG_ADDR_W / REG_DATA_W : default register index / data widths (8 x 16 file)
//   rd_state_t              : read FSM states
//   wbuf_entry_t            : one posted write {rd, data}
package regbus_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    // Field widths follow the package defaults; changing the module widths
    // means changing these defaults too.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/regbus_if.sv
// register_bus: the link between the initiator and the 8x16 register file.
//   rd/data_in/we : level-sensitive write port (driven by the initiator)
//   rs1/rs2       : read addresses (driven by the initiator)
//   data_rs1/2    : read data (driven by the register file)
// Modports: master = initiator side, slave = register file side.
interface regbus_if
    import regbus_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);

    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data_in;
    logic              we;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] data_rs1;
    logic [DATA_W-1:0] data_rs2;

    modport master (
        output rd, data_in, we, rs1, rs2,
        input  data_rs1, data_rs2
    );

    modport slave (
        input  rd, data_in, we, rs1, rs2,
        output data_rs1, data_rs2
    );

endinterface

// File: rtl/regbus_wbuf.sv
// Posted-write FIFO with a youngest-match search for read forwarding.
//   push/push_entry : enqueue (caller guarantees !full)
//   pop/head        : dequeue the oldest entry (caller guarantees !empty)
//   empty/full      : occupancy flags
//   lkN_idx -> lkN_hit/lkN_data : youngest entry whose rd matches lkN_idx
// Entries are kept compacted at mem[0..count-1], oldest at index 0, so the
// search simply lets the highest matching index win.
module regbus_wbuf
    import regbus_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wbuf_entry_t       push_entry,
    input  logic              pop,
    output wbuf_entry_t       head,
    output logic              empty,
    output logic              full,
    input  logic [ADDR_W-1:0] lk0_idx,
    output logic              lk0_hit,
    output logic [DATA_W-1:0] lk0_data,
    input  logic [ADDR_W-1:0] lk1_idx,
    output logic              lk1_hit,
    output logic [DATA_W-1:0] lk1_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wbuf_entry_t      mem   [DEPTH];
    wbuf_entry_t      mem_n [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;

    // Pop shifts everything down one slot; a simultaneous push then lands
    // just above the surviving entries.
    always_comb begin
        mem_n   = mem;
        count_n = count;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_n[i] = mem[i+1];
            end
            count_n = count_n - CNT_W'(1);
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count_n) begin
                    mem_n[i] = push_entry;
                end
            end
            count_n = count_n + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_n;
        end
    end

    // Payload needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        mem <= mem_n;
    end

    assign head  = mem[0];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_comb begin
        lk0_hit  = 1'b0;
        lk0_data = '0;
        lk1_hit  = 1'b0;
        lk1_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count && mem[i].rd == lk0_idx) begin
                lk0_hit  = 1'b1;
                lk0_data = mem[i].data;
            end
            if (CNT_W'(i) < count && mem[i].rd == lk1_idx) begin
                lk1_hit  = 1'b1;
                lk1_data = mem[i].data;
            end
        end
    end

endmodule

// File: rtl/regbus_initiator.sv
// Initiator end of register_bus: turns pipeline write/read requests into
// glitch-free register-file bus activity.
//   clk, rst            : clock, synchronous active-high reset
//   wr_valid/wr_ready   : write request handshake (wr_rd, wr_data)
//   drain_hold          : freeze draining of the posted-write buffer
//   wbuf_empty          : nothing buffered and no write on the bus
//   rd_req_valid/ready  : read request handshake (rs1, rs2)
//   rd_rsp_valid        : one-cycle strobe with rs1_data/rs2_data
//   rb                  : register_bus (master modport)
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high; valid may not depend on ready, and the request fields are only
// sampled on that edge. rd_rsp_valid has no back-pressure.
module regbus_initiator
    import regbus_pkg::*;
#(
    parameter int DATA_W     = REG_DATA_W,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int WBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_hold,
    output logic              wbuf_empty,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rd_rsp_valid,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    regbus_if.master          rb
);

    wbuf_entry_t       push_entry;
    wbuf_entry_t       head;
    logic              buf_empty;
    logic              buf_full;
    logic              push;
    logic              pop;
    logic              hit1;
    logic              hit2;
    logic [DATA_W-1:0] hit1_data;
    logic [DATA_W-1:0] hit2_data;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;
    rd_state_t         rd_state;

    assign wr_ready   = !buf_full;
    assign push       = wr_valid && wr_ready;
    assign pop        = !buf_empty && !drain_hold;
    assign push_entry = '{rd: wr_rd, data: wr_data};
    assign wbuf_empty = buf_empty && !rb.we;

    regbus_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (buf_empty),
        .full       (buf_full),
        .lk0_idx    (rb.rs1),
        .lk0_hit    (hit1),
        .lk0_data   (hit1_data),
        .lk1_idx    (rb.rs2),
        .lk1_hit    (hit2),
        .lk1_data   (hit2_data)
    );

    // Write port: one rb_we pulse per popped entry; rd/data_in hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rb.we      <= 1'b0;
            rb.rd      <= '0;
            rb.data_in <= '0;
        end else begin
            rb.we <= pop;
            if (pop) begin
                rb.rd      <= head.rd;
                rb.data_in <= head.data;
            end
        end
    end

    // Forwarding: a buffered write is newer than the one on the bus, which
    // the register file only commits at the end of this cycle.
    always_comb begin
        if (hit1) begin
            fwd1 = hit1_data;
        end else if (rb.we && rb.rd == rb.rs1) begin
            fwd1 = rb.data_in;
        end else begin
            fwd1 = rb.data_rs1;
        end
        if (hit2) begin
            fwd2 = hit2_data;
        end else if (rb.we && rb.rd == rb.rs2) begin
            fwd2 = rb.data_in;
        end else begin
            fwd2 = rb.data_rs2;
        end
    end

    // Read FSM: IDLE -> ADDR (bus addresses settle) -> RESP (strobe) -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            rd_req_ready <= 1'b1;
            rd_rsp_valid <= 1'b0;
            rb.rs1       <= '0;
            rb.rs2       <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_req_valid && rd_req_ready) begin
                        rb.rs1       <= rs1;
                        rb.rs2       <= rs2;
                        rd_req_ready <= 1'b0;
                        rd_state     <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    rs1_data     <= fwd1;
                    rs2_data     <= fwd2;
                    rd_rsp_valid <= 1'b1;
                    rd_state     <= R_RESP;
                end
                R_RESP: begin
                    rd_rsp_valid <= 1'b0;
                    rd_req_ready <= 1'b1;
                    rd_state     <= R_IDLE;
                end
                default: begin
                    rd_rsp_valid <= 1'b0;
                    rd_req_ready <= 1'b1;
                    rd_state     <= R_IDLE;
                end
            endcase
        end
    end

endmodule
